// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the eight-lane round-robin arbiter: lane/select sizes,
// arbiter state and the rotating-priority search.
package mux8_arb_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;

  localparam logic [SEL_W-1:0] PTR_RESET = 3'd7;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             any;
    logic [SEL_W-1:0] winner;
  } rr_result_t;

  // First set bit of valid searching from ptr+1 upward, wrapping modulo 8.
  // Walking k downward lets the nearest candidate overwrite farther ones.
  function automatic rr_result_t rr_pick(input logic [NUM_LANES-1:0] valid,
                                         input logic [SEL_W-1:0]     ptr);
    rr_result_t       res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (valid[idx]) begin
        res.any    = 1'b1;
        res.winner = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Lane-side and output-side valid/ready channels of the eight-lane arbiter.
interface mux8_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [7:0]         in_valid;
  logic [7:0]         in_last;
  logic [8*WIDTH-1:0] in_data;
  logic [7:0]         in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [2:0]         out_sel;

  // master: requesters plus sink; slave: the arbiter itself
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/mux8_rr_arbiter_lane_mux8.sv
// Combinational WIDTH-wide 8:1 lane mux: two 4:1 stages on sel[1:0] feeding
// a 2:1 stage on sel[2].
module lane_mux8
  import mux8_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [NUM_LANES*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out_data
);

  logic [WIDTH-1:0] lanes [NUM_LANES];
  logic [WIDTH-1:0] half_out [2];

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_unpack
    assign lanes[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_out[gi] = lanes[{1'(gi), sel[1:0]}];
  end

  assign out_data = sel[2] ? half_out[1] : half_out[0];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 byte-lane mux between eight valid/ready
// requesters, with a registered output beat and burst locking.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  mux8_rr_arbiter_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] lock_lane_q, lock_lane_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  rr_result_t           rr;
  logic                 load;
  logic                 cand;
  logic                 accept;
  logic [SEL_W-1:0]     sel;
  logic [NUM_LANES-1:0] sel_oh;
  logic [NUM_LANES-1:0] in_ready;
  logic [WIDTH-1:0]     mux_data;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_onehot
    assign sel_oh[gi] = (sel == SEL_W'(gi));
  end

  lane_mux8 #(.WIDTH(WIDTH)) u_lane_mux (
    .in_data (bus.in_data),
    .sel     (sel),
    .out_data(mux_data)
  );

  // While locked the burst owner is offered ready even before it presents
  // valid, so no other lane can slip a beat into the middle of a burst.
  always_comb begin
    rr   = rr_pick(bus.in_valid, ptr_q);
    load = !out_valid_q || bus.out_ready;
    if (state_q == LOCKED) begin
      sel  = lock_lane_q;
      cand = 1'b1;
    end else begin
      sel  = rr.winner;
      cand = rr.any;
    end
    in_ready = (!rst && load && cand) ? sel_oh : '0;
    accept   = |(in_ready & bus.in_valid);

    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_lane_d = lock_lane_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = bus.in_last[sel];
      out_sel_d   = sel;
      ptr_d       = sel;
      lock_lane_d = sel;
      state_d     = bus.in_last[sel] ? IDLE : LOCKED;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_RESET;
      lock_lane_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_lane_q <= lock_lane_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: constant vector table, directed
// burst/backpressure/reset sequences and a randomized run against a model.
module tb_mux8_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux8_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux8_rr_arbiter #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [7:0] ld [8];

  // reference model state
  int         m_ptr;
  bit         m_locked;
  int         m_lock;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_ol;
  int         m_os;

  int         acc_lane;
  logic [7:0] rdy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ptr = 7; m_locked = 0; m_lock = 0;
    m_ov = 0; m_od = 8'h00; m_ol = 0; m_os = 0;
  endtask

  task automatic drive(input logic [7:0] v, input logic [7:0] l, input logic ordy);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.out_ready = ordy;
    for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = ld[i];
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    check({tag, " out_data"},  32'(bus.out_data),  32'(m_od));
    check({tag, " out_last"},  32'(bus.out_last),  32'(m_ol));
    check({tag, " out_sel"},   32'(bus.out_sel),   32'(m_os));
  endtask

  task automatic do_reset(input logic [7:0] v, input logic [7:0] l);
    @(negedge clk);
    rst = 1'b1;
    drive(v, l, 1'b1);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    check_outputs("reset");
    $display("cyc %0d reset", cyc);
  endtask

  // One clock: drive, check in_ready against the model, advance the model,
  // then check the registered outputs after the edge.
  task automatic step(input logic [7:0] v, input logic [7:0] l, input logic ordy, input string tag);
    bit         load;
    int         g;
    logic [7:0] exp_rdy;
    @(negedge clk);
    rst = 1'b0;
    drive(v, l, ordy);
    #1;
    load    = !m_ov || ordy;
    g       = -1;
    exp_rdy = 8'h00;
    if (load) begin
      if (m_locked) g = m_lock;
      else
        for (int k = 1; k <= 8; k++) begin
          int lane;
          lane = (m_ptr + k) % 8;
          if (g < 0 && v[lane]) g = lane;
        end
    end
    if (g >= 0) exp_rdy = 8'(1 << g);
    rdy_seen = bus.in_ready;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    acc_lane = -1;
    if (g >= 0 && v[g]) begin
      acc_lane = g;
      m_ov = 1; m_od = ld[g]; m_ol = l[g]; m_os = g;
      m_ptr = g; m_locked = !l[g]; m_lock = g;
    end else if (load) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs(tag);
    $display("cyc %0d v=%02h l=%02h ordy=%0b rdy=%02h acc=%0d | ov=%0b sel=%0d data=%02h last=%0b",
             cyc, v, l, ordy, rdy_seen, acc_lane, bus.out_valid, bus.out_sel, bus.out_data, bus.out_last);
  endtask

  typedef struct {
    logic [7:0] v;
    logic [7:0] l;
    logic       ordy;
    logic [7:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int seq [$];
    int cnt [8];
    int beats;
    bit six_done;

    for (int i = 0; i < 8; i++) ld[i] = 8'(8'h10 + i);
    drive(8'h00, 8'h00, 1'b0);

    tbl[0]  = '{8'h29, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0};
    tbl[1]  = '{8'h29, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3};
    tbl[2]  = '{8'h29, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
    tbl[3]  = '{8'h29, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0};
    tbl[4]  = '{8'h29, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3};
    tbl[5]  = '{8'h29, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    tbl[6]  = '{8'h29, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    tbl[7]  = '{8'h29, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd3};
    tbl[8]  = '{8'h29, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd5};
    tbl[9]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd5};
    tbl[10] = '{8'h80, 8'hFF, 1'b0, 8'h80, 1'b1, 3'd7};
    tbl[11] = '{8'h81, 8'hFF, 1'b1, 8'h01, 1'b1, 3'd0};

    do_reset(8'h00, 8'h00);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].ordy, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d vec in_ready", i), 32'(rdy_seen), 32'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d vec out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
      check($sformatf("tbl%0d vec out_sel", i), 32'(bus.out_sel), 32'(tbl[i].exp_sel));
      check($sformatf("tbl%0d vec lane map", i), 32'(bus.out_data), 32'(8'h10) + 32'(tbl[i].exp_sel));
    end

    // backpressure: 0xA5 must stay put and all lanes stay blocked
    ld[0] = 8'hA5;
    step(8'h01, 8'hFF, 1'b1, "hold load");
    check("hold first data", 32'(bus.out_data), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step(8'h09, 8'hFF, 1'b0, "hold");
      check("hold data", 32'(bus.out_data), 32'hA5);
      check("hold in_ready", 32'(rdy_seen), 32'h0);
    end
    step(8'h08, 8'hFF, 1'b1, "release");
    check("release data", 32'(bus.out_data), 32'h13);
    ld[0] = 8'h10;

    // lane 2 four-beat burst with lane 6 waiting
    do_reset(8'h00, 8'h00);
    beats = 0;
    six_done = 0;
    for (int c = 0; c < 10; c++) begin
      logic [7:0] v, l;
      v = ((beats < 4) ? 8'h04 : 8'h00) | (six_done ? 8'h00 : 8'h40);
      l = 8'h40 | ((beats == 3) ? 8'h04 : 8'h00);
      step(v, l, 1'b1, "burst");
      if (acc_lane == 2) beats++;
      if (acc_lane == 6) six_done = 1;
      if (bus.out_valid) seq.push_back(int'(bus.out_sel));
    end
    check("burst beat count", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++)
      check($sformatf("burst order %0d", i), 32'(seq[i]), (i < 4) ? 32'd2 : 32'd6);

    // all lanes valid: strict 0..7 rotation, twice
    do_reset(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 8'hFF, 1'b1, "rotate");
      check($sformatf("rotate grant %0d", i), 32'(acc_lane), 32'(i % 8));
      if (acc_lane >= 0) cnt[acc_lane]++;
    end
    for (int i = 0; i < 8; i++) check($sformatf("rotate count lane%0d", i), 32'(cnt[i]), 32'd2);

    // reset in the middle of a lane-4 burst
    do_reset(8'h00, 8'h00);
    step(8'h10, 8'h00, 1'b1, "mid burst");
    step(8'h10, 8'h00, 1'b1, "mid burst");
    do_reset(8'h12, 8'h00);
    check("mid reset out_valid", 32'(bus.out_valid), 32'h0);
    step(8'h12, 8'h00, 1'b1, "after reset");
    check("after reset grant", 32'(acc_lane), 32'd1);

    // randomized traffic against the model
    do_reset(8'h00, 8'h00);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] v, l;
      for (int j = 0; j < 8; j++) ld[j] = 8'($urandom);
      v = 8'($urandom) & 8'($urandom | 32'h55);
      l = 8'($urandom);
      step(v, l, ($urandom_range(0, 3) != 0), "rand");
      check("rand onehot", 32'($countones(rdy_seen) <= 1), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
